keypad_scanner: RTL and testbench

//  Parametrised successor to the 4-column matrix key decoder. Drives keypad rows one at a time
//  and samples the column returns through a synchroniser. Debounces over whole scan frames and

---
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned matrix keypad with frame debounce, multi-key flag,
// overrun detection and a valid/ack key-code event output.
module keypad_scanner #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 3,
    localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [COLS-1:0]   i_cols,
    input  logic              i_key_ack,
    output logic [ROWS-1:0]   o_rows,
    output logic [CODE_W-1:0] o_key_code,
    output logic              o_key_valid,
    output logic              o_key_multi,
    output logic              o_key_pressed,
    output logic              o_overrun
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;

    state_t            state, state_n;
    logic              started;
    logic [DW-1:0]     dwell;
    logic [RW-1:0]     row;
    logic [COLS-1:0]   sync1, sync2;
    logic [N-1:0]      bitmap, prev, frame;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc;
    logic              sample, frame_end, accept, many, drop;
    logic [CODE_W-1:0] low_idx;

    assign sample        = started && dwell == DW'(SCAN_DIV - 1);
    assign frame_end     = sample && row == RW'(ROWS - 1);
    assign o_rows        = started ? ~(ROWS'(1) << row) : '1;
    assign o_key_pressed = state == HELD;
    assign cnt_inc       = cnt + CW'(1);
    assign many          = (frame & (frame - N'(1))) != '0;
    assign drop          = o_key_valid && !i_key_ack;

    // Bitmap as it will look once the row being sampled this cycle is stored
    always_comb begin
        frame = bitmap;
        frame[int'(row) * COLS +: COLS] = ~sync2;
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (frame[i]) low_idx = CODE_W'(i);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: if (frame != '0) begin
                    if (DEBOUNCE == 1) begin
                        state_n = HELD;
                        cnt_n   = '0;
                        accept  = 1'b1;
                    end else begin
                        state_n = DEB;
                        cnt_n   = CW'(1);
                    end
                end
                DEB: if (frame == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (frame != prev) begin
                    cnt_n = CW'(1);
                end else if (cnt_inc == CW'(DEBOUNCE)) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
                HELD: if (frame != '0) begin
                    cnt_n = '0;
                end else if (cnt_inc == CW'(DEBOUNCE)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            started     <= 1'b0;
            dwell       <= '0;
            row         <= '0;
            sync1       <= '0;
            sync2       <= '0;
            bitmap      <= '0;
            prev        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            o_key_code  <= '0;
            o_key_valid <= 1'b0;
            o_key_multi <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            started   <= 1'b1;
            sync1     <= i_cols;
            sync2     <= sync1;
            state     <= state_n;
            cnt       <= cnt_n;
            o_overrun <= accept && drop;
            if (started) dwell <= sample ? '0 : dwell + DW'(1);
            if (sample) begin
                bitmap <= frame;
                row    <= frame_end ? '0 : row + RW'(1);
            end
            if (frame_end) prev <= frame;
            if (accept && !drop) begin
                o_key_valid <= 1'b1;
                o_key_code  <= low_idx;
                o_key_multi <= many;
            end else if (i_key_ack) begin
                o_key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-aligned keypad stimulus against a run-length debounce model,
// plus a second small-geometry instance.
module tb_keypad_scanner;
    localparam int R = 4, C = 4, SD = 16, DB = 3;

    logic       clk = 1'b0, rst_n = 1'b0, ack = 1'b0, ack2 = 1'b0;
    logic [3:0] cols, rows, code;
    logic       valid, multi, pressed, ovr;
    logic [2:0] cols2, code2;
    logic [1:0] rows2;
    logic       valid2, multi2, pressed2, ovr2;
    logic [15:0] keys = '0;
    logic [5:0]  keys2 = '0;
    int n_cmp = 0, n_bad = 0;

    bit         m_pressed, m_valid, m_multi;
    int         m_run;
    logic [15:0] m_last;
    logic [3:0] m_code;

    always #5 clk = ~clk;

    // Passive matrix: a column reads low when a closed key sits on the driven row
    always_comb begin
        cols = '1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (!rows[r] && keys[r * C + c]) cols[c] = 1'b0;
        cols2 = '1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                if (!rows2[r] && keys2[r * 3 + c]) cols2[c] = 1'b0;
    end

    keypad_scanner #(.ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cols(cols), .i_key_ack(ack),
        .o_rows(rows), .o_key_code(code), .o_key_valid(valid), .o_key_multi(multi),
        .o_key_pressed(pressed), .o_overrun(ovr)
    );

    keypad_scanner #(.ROWS(2), .COLS(3), .SCAN_DIV(SD), .DEBOUNCE(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cols(cols2), .i_key_ack(ack2),
        .o_rows(rows2), .o_key_code(code2), .o_key_valid(valid2), .o_key_multi(multi2),
        .o_key_pressed(pressed2), .o_overrun(ovr2)
    );

    // Leaves time at 1 unit after the first edge following reset release
    task automatic do_reset();
        rst_n = 1'b0;
        ack = 1'b0;
        ack2 = 1'b0;
        keys = '0;
        keys2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_pressed = 0;
        m_valid = 0;
        m_multi = 0;
        m_run = 0;
        m_last = '0;
        m_code = '0;
    endtask

    // One full scan frame with a fixed key set; mode 1 acks on the first edge, mode 2 on the frame-end edge
    task automatic run_frame(input string tag, input logic [15:0] mask, input int mode);
        bit ev, e_ovr;
        keys = mask;
        ack = (mode == 1);
        @(posedge clk);
        #1 ack = 1'b0;
        repeat (R * SD - 2) @(posedge clk);
        #1 ack = (mode == 2);
        @(posedge clk);
        #1 ack = 1'b0;
        if (mode == 1) m_valid = 0;
        ev = 0;
        e_ovr = 0;
        if (!m_pressed) begin
            m_run = (mask == '0) ? 0 : (mask == m_last && m_run > 0) ? m_run + 1 : 1;
            if (m_run >= DB) begin
                m_pressed = 1;
                m_run = 0;
                ev = 1;
            end
        end else begin
            m_run = (mask == '0) ? m_run + 1 : 0;
            if (m_run >= DB) begin
                m_pressed = 0;
                m_run = 0;
            end
        end
        m_last = mask;
        if (ev && m_valid && mode != 2) begin
            e_ovr = 1;
        end else if (ev) begin
            m_valid = 1;
            m_multi = $countones(mask) > 1;
            for (int i = 15; i >= 0; i--)
                if (mask[i]) m_code = 4'(i);
        end else if (mode == 2) begin
            m_valid = 0;
        end
        n_cmp += 3;
        if (valid !== m_valid) begin
            n_bad++;
            $display("FAIL %s valid: got %b want %b", tag, valid, m_valid);
        end
        if (pressed !== m_pressed) begin
            n_bad++;
            $display("FAIL %s pressed: got %b want %b", tag, pressed, m_pressed);
        end
        if (ovr !== e_ovr) begin
            n_bad++;
            $display("FAIL %s overrun: got %b want %b", tag, ovr, e_ovr);
        end
        if (m_valid) begin
            n_cmp += 2;
            if (code !== m_code) begin
                n_bad++;
                $display("FAIL %s code: got %0d want %0d", tag, code, m_code);
            end
            if (multi !== m_multi) begin
                n_bad++;
                $display("FAIL %s multi: got %b want %b", tag, multi, m_multi);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] er;
        do_reset();
        n_cmp++;
        if (rows !== 4'b1110) begin
            n_bad++;
            $display("FAIL reset_row0: got %b want 1110", rows);
        end
        repeat (15) @(posedge clk);
        #1 n_cmp++;
        if (rows !== 4'b1110) begin
            n_bad++;
            $display("FAIL reset_dwell: got %b want 1110", rows);
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (k == 1 ? 1 : SD) @(posedge clk);
            er = ~(4'b0001 << (k % 4));
            #1 n_cmp++;
            if (rows !== er) begin
                n_bad++;
                $display("FAIL row_rotate%0d: got %b want %b", k, rows, er);
            end
        end
        do_reset();
        repeat (3) run_frame("pre_reset", 16'h0200, 0);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 n_cmp++;
        if ({rows, valid, pressed, ovr, code, multi} !== {4'b1111, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got rows=%b v=%b p=%b o=%b c=%0d want rows=1111 all zero",
                     rows, valid, pressed, ovr, code);
        end
        do_reset();
    endtask

    task automatic test_single_key();
        do_reset();
        repeat (3) run_frame("single9", 16'h0200, 0);
        n_cmp++;
        if (code !== 4'd9 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single9_event: got v=%b code=%0d want v=1 code=9", valid, code);
        end
        run_frame("single9_ack", 16'h0200, 1);
        repeat (3) run_frame("single9_rel", 16'h0000, 0);
    endtask

    task automatic test_bounce();
        do_reset();
        for (int f = 0; f < 8; f++) run_frame("bounce", f[0] ? 16'h0000 : 16'h0200, 0);
        repeat (3) run_frame("bounce_stable", 16'h0200, 0);
        repeat (4) run_frame("bounce_rel", 16'h0000, 0);
    endtask

    task automatic test_multi_key();
        do_reset();
        repeat (3) run_frame("multi", 16'h4020, 0);
        run_frame("multi_ack", 16'h0000, 1);
        repeat (2) run_frame("multi_rel", 16'h0000, 0);
        run_frame("multi_idle", 16'h0000, 0);
    endtask

    task automatic test_overrun();
        do_reset();
        repeat (3) run_frame("ovr_first", 16'h0200, 0);
        repeat (3) run_frame("ovr_rel", 16'h0000, 0);
        repeat (3) run_frame("ovr_second", 16'h0008, 0);
        run_frame("ovr_after", 16'h0008, 0);
        repeat (3) run_frame("ovr_rel2", 16'h0000, 0);
        repeat (2) run_frame("b2b", 16'h0008, 0);
        run_frame("b2b_ack", 16'h0008, 2);
        n_cmp++;
        if (code !== 4'd3 || valid !== 1'b1 || ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_load: got v=%b code=%0d ovr=%b want v=1 code=3 ovr=0", valid, code, ovr);
        end
    endtask

    task automatic test_small_config();
        do_reset();
        keys2 = 6'b100000;
        repeat (2 * SD - 1) @(posedge clk);
        #1 n_cmp++;
        if (valid2 !== 1'b0) begin
            n_bad++;
            $display("FAIL small_early: got v=%b want 0", valid2);
        end
        @(posedge clk);
        #1 n_cmp++;
        if ({valid2, code2, multi2, pressed2, rows2} !== {1'b1, 3'd5, 1'b0, 1'b1, 2'b10}) begin
            n_bad++;
            $display("FAIL small_event: got v=%b code=%0d m=%b p=%b rows=%b want 1 5 0 1 10",
                     valid2, code2, multi2, pressed2, rows2);
        end
        keys2 = '0;
        repeat (2 * SD) @(posedge clk);
        #1 n_cmp++;
        if ({pressed2, valid2} !== 2'b01) begin
            n_bad++;
            $display("FAIL small_release: got p=%b v=%b want p=0 v=1", pressed2, valid2);
        end
        ack2 = 1'b1;
        @(posedge clk);
        #1 ack2 = 1'b0;
        n_cmp++;
        if (valid2 !== 1'b0) begin
            n_bad++;
            $display("FAIL small_ack: got v=%b want 0", valid2);
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int r, hold, md;
        do_reset();
        for (int f = 0; f < 60; ) begin
            r = $urandom_range(0, 9);
            mask = '0;
            if (r >= 3) mask[$urandom_range(0, 15)] = 1'b1;
            if (r >= 8) mask[$urandom_range(0, 15)] = 1'b1;
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++, f++) begin
                md = $urandom_range(0, 3);
                run_frame("random", mask, md < 2 ? 0 : md - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_small_config();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
